// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cnn_pkg                                                       |
// | Brief    : Shared sample/window types and feature-map dimensions.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package cnn_pkg;

    localparam int DATA_W     = 22;
    localparam int CONV_OUT_W = 126;
    localparam int CONV_OUT_H = 126;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t tl;
        sample_t tr;
        sample_t bl;
        sample_t br;
    } window_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } pool_state_t;

endpackage
`default_nettype wire

// File: rtl/pool_line_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pool_line_ram                                                 |
// | Brief    : Single-port row buffer, combinational read-before-write.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pool_line_ram #(
    parameter int DATA_W = 22,
    parameter int DEPTH  = 126,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are intentionally not reset so this maps onto distributed RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool_window_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pool_window_buffer                                            |
// | Brief    : Raster stream to non-overlapping 2x2 windows for max pooling. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pool_window_buffer #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IMG_W  = cnn_pkg::CONV_OUT_W,
    parameter int IMG_H  = cnn_pkg::CONV_OUT_H,
    parameter int COL_W  = $clog2(IMG_W),
    parameter int ROW_W  = $clog2(IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic signed [DATA_W-1:0] win_tl,
    output logic signed [DATA_W-1:0] win_tr,
    output logic signed [DATA_W-1:0] win_bl,
    output logic signed [DATA_W-1:0] win_br,
    output logic                     win_valid,
    output logic [COL_W-1:0]         win_col,
    output logic [ROW_W-1:0]         win_row,
    output logic                     frame_done
);

    import cnn_pkg::*;

    localparam logic [COL_W-1:0] c_last_col  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_last_row  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] c_last_wcol = COL_W'(IMG_W / 2 - 1);
    localparam logic [ROW_W-1:0] c_last_wrow = ROW_W'(IMG_H / 2 - 1);

    pool_state_t              state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic signed [DATA_W-1:0] prev_top_q, prev_top_d;
    logic signed [DATA_W-1:0] prev_cur_q, prev_cur_d;
    logic signed [DATA_W-1:0] tl_q, tl_d, tr_q, tr_d, bl_q, bl_d, br_q, br_d;
    logic                     win_valid_q, win_valid_d;
    logic [COL_W-1:0]         win_col_q, win_col_d;
    logic [ROW_W-1:0]         win_row_q, win_row_d;
    logic                     frame_done_q, frame_done_d;

    logic                     w_accept;
    pool_state_t              w_cur_state;
    logic [COL_W-1:0]         w_pos_col;
    logic [ROW_W-1:0]         w_pos_row;
    logic [DATA_W-1:0]        w_ram_rd;

    // frame_start re-targets the current sample to pixel (0,0) in any state.
    assign w_accept    = in_valid && (frame_start || (state_q != ST_IDLE));
    assign w_cur_state = frame_start ? ST_FILL : state_q;
    assign w_pos_col   = frame_start ? '0 : col_q;
    assign w_pos_row   = frame_start ? '0 : row_q;

    pool_line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_line_ram (
        .clk     (clk),
        .we_i    (w_accept),
        .addr_i  (w_pos_col),
        .wdata_i (in_data),
        .rdata_o (w_ram_rd)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        prev_top_d   = prev_top_q;
        prev_cur_d   = prev_cur_q;
        tl_d         = tl_q;
        tr_d         = tr_q;
        bl_d         = bl_q;
        br_d         = br_q;
        win_valid_d  = 1'b0;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        frame_done_d = 1'b0;

        if (w_accept) begin
            prev_top_d = w_ram_rd;
            prev_cur_d = in_data;

            if ((w_cur_state == ST_EMIT) && w_pos_col[0]) begin
                tl_d         = prev_top_q;
                tr_d         = w_ram_rd;
                bl_d         = prev_cur_q;
                br_d         = in_data;
                win_valid_d  = 1'b1;
                win_col_d    = w_pos_col >> 1;
                win_row_d    = w_pos_row >> 1;
                frame_done_d = ((w_pos_col >> 1) == c_last_wcol) &&
                               ((w_pos_row >> 1) == c_last_wrow);
            end

            if (w_pos_col == c_last_col) begin
                col_d = '0;
                if (w_pos_row == c_last_row) begin
                    row_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    row_d   = w_pos_row + ROW_W'(1);
                    state_d = (w_cur_state == ST_FILL) ? ST_EMIT : ST_FILL;
                end
            end else begin
                col_d   = w_pos_col + COL_W'(1);
                row_d   = w_pos_row;
                state_d = w_cur_state;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            prev_top_q   <= '0;
            prev_cur_q   <= '0;
            tl_q         <= '0;
            tr_q         <= '0;
            bl_q         <= '0;
            br_q         <= '0;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            prev_top_q   <= prev_top_d;
            prev_cur_q   <= prev_cur_d;
            tl_q         <= tl_d;
            tr_q         <= tr_d;
            bl_q         <= bl_d;
            br_q         <= br_d;
            win_valid_q  <= win_valid_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_tl     = tl_q;
    assign win_tr     = tr_q;
    assign win_bl     = bl_q;
    assign win_br     = br_q;
    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_window_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pool_window_buffer                                         |
// | Brief    : Randomised bench for pool_window_buffer (4x4 and 5x3 builds). |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pool_window_buffer;

    import cnn_pkg::*;

    logic    clk         = 1'b0;
    logic    rst_n       = 1'b0;
    logic    frame_start = 1'b0;
    logic    in_valid    = 1'b0;
    sample_t in_data     = '0;
    logic    sel         = 1'b0;   // 0: 4x4 instance, 1: 5x3 instance

    logic    v4, v5;
    assign v4 = in_valid & ~sel;
    assign v5 = in_valid &  sel;

    sample_t    a_tl, a_tr, a_bl, a_br;
    logic       a_valid, a_done;
    logic [1:0] a_col, a_row;
    sample_t    b_tl, b_tr, b_bl, b_br;
    logic       b_valid, b_done;
    logic [2:0] b_col;
    logic [1:0] b_row;

    always #5 clk = ~clk;

    pool_window_buffer #(.DATA_W(22), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(v4),
        .in_data(in_data), .win_tl(a_tl), .win_tr(a_tr), .win_bl(a_bl),
        .win_br(a_br), .win_valid(a_valid), .win_col(a_col), .win_row(a_row),
        .frame_done(a_done)
    );

    pool_window_buffer #(.DATA_W(22), .IMG_W(5), .IMG_H(3)) dut_odd (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(v5),
        .in_data(in_data), .win_tl(b_tl), .win_tr(b_tr), .win_bl(b_bl),
        .win_br(b_br), .win_valid(b_valid), .win_col(b_col), .win_row(b_row),
        .frame_done(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pixel-level reference: store the frame, emit a window at every odd/odd pixel.
    int      m_w, m_h, m_r, m_c;
    bit      m_active;
    sample_t img [8][8];
    window_t e_win;
    int      e_col, e_row;
    bit      e_valid, e_done;
    window_t obs_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_r = 0; m_c = 0;
        e_valid = 1'b0; e_done = 1'b0;
        e_win = '0; e_col = 0; e_row = 0;
    endtask

    task automatic model_step(input bit v, input bit fs, input sample_t d);
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (v) begin
            if (fs) begin
                m_active = 1'b1; m_r = 0; m_c = 0;
            end
            if (m_active) begin
                img[m_r][m_c] = d;
                if ((m_r % 2 == 1) && (m_c % 2 == 1)) begin
                    e_valid = 1'b1;
                    e_win.tl = img[m_r-1][m_c-1];
                    e_win.tr = img[m_r-1][m_c];
                    e_win.bl = img[m_r][m_c-1];
                    e_win.br = d;
                    e_col = m_c / 2;
                    e_row = m_r / 2;
                    e_done = (e_col == m_w/2 - 1) && (e_row == m_h/2 - 1);
                end
                m_c++;
                if (m_c == m_w) begin
                    m_c = 0;
                    m_r++;
                    if (m_r == m_h) begin
                        m_r = 0;
                        m_active = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic compare_outputs();
        window_t w;
        logic    o_valid, o_done;
        int      o_col, o_row;
        if (sel) begin
            w = '{b_tl, b_tr, b_bl, b_br};
            o_valid = b_valid; o_done = b_done; o_col = int'(b_col); o_row = int'(b_row);
        end else begin
            w = '{a_tl, a_tr, a_bl, a_br};
            o_valid = a_valid; o_done = a_done; o_col = int'(a_col); o_row = int'(a_row);
        end
        if (o_valid) obs_q.push_back(w);
        chk("win_valid",  o_valid, e_valid);
        chk("frame_done", o_done,  e_done);
        chk("win_tl",     w.tl,    e_win.tl);
        chk("win_tr",     w.tr,    e_win.tr);
        chk("win_bl",     w.bl,    e_win.bl);
        chk("win_br",     w.br,    e_win.br);
        chk("win_col",    o_col,   e_col);
        chk("win_row",    o_row,   e_row);
    endtask

    task automatic send(input bit v, input bit fs, input sample_t d);
        @(negedge clk);
        in_valid = v; frame_start = fs; in_data = d;
        model_step(v, fs, d);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; frame_start = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_win(input string tag, input int k, input int t0, input int t1,
                             input int t2, input int t3);
        if (k < obs_q.size()) begin
            chk(tag, obs_q[k].tl, sample_t'(t0));
            chk(tag, obs_q[k].tr, sample_t'(t1));
            chk(tag, obs_q[k].bl, sample_t'(t2));
            chk(tag, obs_q[k].br, sample_t'(t3));
        end
    endtask

    task automatic rand_frame(input int restart_at);
        for (int i = 0; i < m_w * m_h; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) send(1'b0, 1'b0, sample_t'($urandom));
            end
            send(1'b1, (i == 0) || (i == restart_at), sample_t'($urandom));
        end
        repeat ($urandom_range(0, 2)) send(1'b1, 1'b0, sample_t'($urandom));
        send(1'b0, 1'b0, '0);
    endtask

    initial begin
        sample_t sv [16];

        m_w = 4; m_h = 4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic back-to-back 4x4 frame.
        obs_q.delete();
        for (int i = 0; i < 16; i++) send(1'b1, i == 0, sample_t'(i));
        send(1'b0, 1'b0, '0);
        chk("basic_count", obs_q.size(), 4);
        check_win("basic_w0", 0, 0, 1, 4, 5);
        check_win("basic_w1", 1, 2, 3, 6, 7);
        check_win("basic_w2", 2, 8, 9, 12, 13);
        check_win("basic_w3", 3, 10, 11, 14, 15);

        // Signed extremes pass through unchanged.
        obs_q.delete();
        for (int i = 0; i < 16; i++) sv[i] = sample_t'(i + 20);
        sv[0] = sample_t'(22'h3FFFFF);
        sv[1] = sample_t'(22'h200000);
        sv[4] = sample_t'(22'h1FFFFF);
        sv[5] = '0;
        for (int i = 0; i < 16; i++) send(1'b1, i == 0, sv[i]);
        send(1'b0, 1'b0, '0);
        check_win("signed_w0", 0, -1, -2097152, 2097151, 0);

        // Same frame with a 3-cycle gap between every sample.
        obs_q.delete();
        for (int i = 0; i < 16; i++) begin
            send(1'b1, i == 0, sample_t'(i));
            repeat (3) send(1'b0, 1'b0, sample_t'(77));
        end
        chk("gap_count", obs_q.size(), 4);
        check_win("gap_w3", 3, 10, 11, 14, 15);

        // Restart on the sixth sample: the aborted pair must not be windowed.
        obs_q.delete();
        for (int i = 0; i < 5; i++) send(1'b1, i == 0, sample_t'(i));
        for (int i = 0; i < 16; i++) send(1'b1, i == 0, sample_t'(100 + i));
        send(1'b0, 1'b0, '0);
        chk("restart_count", obs_q.size(), 4);
        check_win("restart_w0", 0, 100, 101, 104, 105);

        // Asynchronous reset while a window is being presented.
        for (int i = 0; i < 6; i++) send(1'b1, i == 0, sample_t'(200 + i));
        chk("rst_pending", a_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", a_valid, 1'b0);
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0, sample_t'(300 + i));
        chk("rst_ignored", obs_q.size(), 0);

        for (int f = 0; f < 6; f++) rand_frame((f % 3 == 2) ? int'($urandom_range(1, 14)) : -1);

        // 5x3 instance: floor pooling on both dimensions.
        sel = 1'b1;
        m_w = 5; m_h = 3;
        do_reset();
        obs_q.delete();
        for (int i = 0; i < 15; i++) send(1'b1, i == 0, sample_t'(i));
        repeat (2) send(1'b0, 1'b0, '0);
        chk("odd_count", obs_q.size(), 2);
        check_win("odd_w0", 0, 0, 1, 5, 6);
        check_win("odd_w1", 1, 2, 3, 7, 8);

        for (int f = 0; f < 6; f++) rand_frame((f % 3 == 1) ? int'($urandom_range(1, 13)) : -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
